// File: rtl/burst_bus_arbiter_pkg.sv
// Shared types and default sizes for the PSRAM burst-bus arbiter.
//   burst_cmd_e    : command encoding on the burst bus (1 = write, 0 = read)
//   arb_state_e    : arbiter FSM states
//   PSRAM_*        : default address/data width and beats per burst
package burst_bus_arbiter_pkg;

  typedef enum bit {BURST_READ, BURST_WRITE} burst_cmd_e;

  typedef enum logic [1:0] {StIdle, StWrite, StRead} arb_state_e;

  parameter int unsigned PSRAM_ADDR_WIDTH  = 21;
  parameter int unsigned PSRAM_DATA_WIDTH  = 64;
  parameter int unsigned PSRAM_BURST_BEATS = 4;

endpackage

// File: rtl/burst_bus_arbiter.sv
// Round-robin N-to-1 arbiter sharing one PSRAM burst-bus controller between several
// burst-bus masters. The grant is locked for a whole write burst or read return, and
// read beats are routed back only to the master that issued the read.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_m_cmd/_cmd_en/_addr/_wr_data/_data_mask : packed per-master command side
//   o_m_ready               : per-master ready, at most one bit high
//   o_m_rd_data             : read data broadcast to all masters
//   o_m_rd_data_valid       : read beat valid, granted master only
//   o_s_*                   : command side toward the controller
//   i_s_rd_data/_valid, i_s_ready : controller responses
//   o_err                   : sticky, set by a read beat nobody asked for
module burst_bus_arbiter
  import burst_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned BURST_BEATS = PSRAM_BURST_BEATS,
  parameter int unsigned ADDR_WIDTH  = PSRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = PSRAM_DATA_WIDTH
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_MASTERS-1:0]              i_m_cmd,
  input  logic [NUM_MASTERS-1:0]              i_m_cmd_en,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   i_m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   i_m_wr_data,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] i_m_data_mask,
  output logic [NUM_MASTERS-1:0]              o_m_ready,
  output logic [DATA_WIDTH-1:0]               o_m_rd_data,
  output logic [NUM_MASTERS-1:0]              o_m_rd_data_valid,
  output logic                                o_s_cmd,
  output logic                                o_s_cmd_en,
  output logic [ADDR_WIDTH-1:0]               o_s_addr,
  output logic [DATA_WIDTH-1:0]               o_s_wr_data,
  output logic [DATA_WIDTH/8-1:0]             o_s_data_mask,
  input  logic [DATA_WIDTH-1:0]               i_s_rd_data,
  input  logic                                i_s_rd_data_valid,
  input  logic                                i_s_ready,
  output logic                                o_err
);

  localparam int unsigned MaskW = DATA_WIDTH / 8;
  localparam int unsigned PtrW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CntW  = $clog2(BURST_BEATS + 1);

  arb_state_e      r_state;
  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] r_grant;
  logic [CntW-1:0] r_cnt;
  logic            r_err;

  logic [PtrW-1:0] w_sel;
  logic            w_fire;
  logic            w_is_write;

  function automatic logic [PtrW-1:0] f_next(input logic [PtrW-1:0] p);
    f_next = (p == PtrW'(NUM_MASTERS - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // While idle the offered master drives the controller; otherwise the granted one does.
  assign w_sel      = (r_state == StIdle) ? r_ptr : r_grant;
  assign w_fire     = (r_state == StIdle) && !i_rst && i_s_ready && i_m_cmd_en[r_ptr];
  assign w_is_write = (burst_cmd_e'(i_m_cmd[r_ptr]) == BURST_WRITE);

  always_comb begin
    o_s_cmd       = 1'b0;
    o_s_addr      = '0;
    o_s_wr_data   = '0;
    o_s_data_mask = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_sel == PtrW'(i)) begin
        o_s_cmd       = i_m_cmd[i];
        o_s_addr      = i_m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        o_s_wr_data   = i_m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        o_s_data_mask = i_m_data_mask[i*MaskW +: MaskW];
      end
    end
  end

  always_comb begin
    o_m_ready         = '0;
    o_m_rd_data_valid = '0;
    if (!i_rst && (r_state == StIdle)) begin
      o_m_ready[r_ptr] = i_s_ready;
    end
    if (!i_rst && (r_state == StRead)) begin
      o_m_rd_data_valid[r_grant] = i_s_rd_data_valid;
    end
  end

  assign o_s_cmd_en  = w_fire;
  assign o_m_rd_data = i_s_rd_data;
  assign o_err       = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      // Any beat outside a read return has no owner.
      if (i_s_rd_data_valid && (r_state != StRead)) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (w_fire) begin
            r_grant <= r_ptr;
            if (w_is_write) begin
              if (BURST_BEATS == 1) begin
                r_ptr <= f_next(r_ptr);
              end else begin
                r_state <= StWrite;
                r_cnt   <= CntW'(BURST_BEATS - 1);
              end
            end else begin
              r_state <= StRead;
              r_cnt   <= CntW'(BURST_BEATS);
            end
          end else if (i_s_ready) begin
            // Offered master passed up its turn.
            r_ptr <= f_next(r_ptr);
          end
        end
        StWrite: begin
          r_cnt <= r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            r_state <= StIdle;
            r_ptr   <= f_next(r_grant);
          end
        end
        StRead: begin
          if (i_s_rd_data_valid) begin
            r_cnt <= r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) begin
              r_state <= StIdle;
              r_ptr   <= f_next(r_grant);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_bus_arbiter.sv
// Directed bench for burst_bus_arbiter (2 masters, 4 beats, 21-bit addr, 64-bit data).
// Expected commands and read beats are queued as stimulus is driven and popped by a
// negedge monitor whenever the DUT forwards a command or routes a read beat.
module tb_burst_bus_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned BB = 4;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NM-1:0]        m_cmd;
  logic [NM-1:0]        m_cmd_en;
  logic [NM*AW-1:0]     m_addr;
  logic [NM*DW-1:0]     m_wr_data;
  logic [NM*DW/8-1:0]   m_data_mask;
  logic [NM-1:0]        m_ready;
  logic [DW-1:0]        m_rd_data;
  logic [NM-1:0]        m_rd_data_valid;
  logic                 s_cmd;
  logic                 s_cmd_en;
  logic [AW-1:0]        s_addr;
  logic [DW-1:0]        s_wr_data;
  logic [DW/8-1:0]      s_data_mask;
  logic [DW-1:0]        s_rd_data;
  logic                 s_rd_data_valid;
  logic                 s_ready;
  logic                 err;

  typedef struct {
    int          master;
    logic        cmd;
    logic [20:0] addr;
  } cmd_exp_t;

  typedef struct {
    int          master;
    logic [63:0] data;
  } rd_exp_t;

  cmd_exp_t cmd_q[$];
  rd_exp_t  rd_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  burst_bus_arbiter #(
    .NUM_MASTERS(NM),
    .BURST_BEATS(BB),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_m_cmd          (m_cmd),
    .i_m_cmd_en       (m_cmd_en),
    .i_m_addr         (m_addr),
    .i_m_wr_data      (m_wr_data),
    .i_m_data_mask    (m_data_mask),
    .o_m_ready        (m_ready),
    .o_m_rd_data      (m_rd_data),
    .o_m_rd_data_valid(m_rd_data_valid),
    .o_s_cmd          (s_cmd),
    .o_s_cmd_en       (s_cmd_en),
    .o_s_addr         (s_addr),
    .o_s_wr_data      (s_wr_data),
    .o_s_data_mask    (s_data_mask),
    .i_s_rd_data      (s_rd_data),
    .i_s_rd_data_valid(s_rd_data_valid),
    .i_s_ready        (s_ready),
    .o_err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_cmd(input int m, input logic c, input logic [20:0] a);
    cmd_exp_t e;
    e.master = m;
    e.cmd    = c;
    e.addr   = a;
    cmd_q.push_back(e);
  endtask

  // Four back-to-back controller beats, each expected on master m only.
  task automatic read_beats(input int m, input logic [63:0] base);
    rd_exp_t e;
    for (int k = 0; k < int'(BB); k++) begin
      tick();
      s_rd_data_valid = 1'b1;
      s_rd_data       = base + 64'(k);
      e.master        = m;
      e.data          = s_rd_data;
      rd_q.push_back(e);
      sample();
      check("rd_route", {62'd0, m_rd_data_valid}, 64'd1 << m);
    end
  endtask

  // Master 0 write beats 1..3 after the command cycle.
  task automatic write_beats(input logic [63:0] base);
    for (int b = 1; b < int'(BB); b++) begin
      tick();
      m_wr_data[63:0] = base + 64'(b);
      sample();
      check("wr_beat_data", s_wr_data, base + 64'(b));
      check("wr_beat_ready", {62'd0, m_ready}, 64'd0);
      check("wr_beat_no_cmd", {63'd0, s_cmd_en}, 64'd0);
    end
  endtask

  // Monitor: one-hot ready, and every forwarded command / routed beat must be expected.
  always @(negedge clk) begin
    cmd_exp_t ce;
    rd_exp_t  re;
    check("ready_onehot0", {63'd0, $onehot0(m_ready)}, 64'd1);
    if (s_cmd_en) begin
      if (cmd_q.size() == 0) begin
        check("cmd_unexpected", {63'd0, s_cmd_en}, 64'd0);
      end else begin
        ce = cmd_q.pop_front();
        check("cmd_type", {63'd0, s_cmd}, {63'd0, ce.cmd});
        check("cmd_addr", {43'd0, s_addr}, {43'd0, ce.addr});
        check("cmd_ready_bit", {63'd0, m_ready[ce.master]}, 64'd1);
      end
    end
    if (m_rd_data_valid != '0) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", {62'd0, m_rd_data_valid}, 64'd0);
      end else begin
        re = rd_q.pop_front();
        check("rd_valid_bits", {62'd0, m_rd_data_valid}, 64'd1 << re.master);
        check("rd_data", m_rd_data, re.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    m_cmd           = '0;
    m_cmd_en        = 2'b01;
    m_addr          = '0;
    m_wr_data       = '0;
    m_data_mask     = '0;
    s_rd_data       = '0;
    s_rd_data_valid = 1'b0;
    s_ready         = 1'b1;

    // Reset: strobe and ready present but nothing may come out.
    tick();
    tick();
    sample();
    check("rst_ready", {62'd0, m_ready}, 64'd0);
    check("rst_cmd_en", {63'd0, s_cmd_en}, 64'd0);
    check("rst_rd_valid", {62'd0, m_rd_data_valid}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);

    tick();
    rst      = 1'b0;
    m_cmd_en = '0;
    sample();
    check("reset_ptr0", {62'd0, m_ready}, 64'd1);

    // Lone read from master 1 on its first offer cycle.
    tick();
    m_cmd[1]          = 1'b0;
    m_cmd_en[1]       = 1'b1;
    m_addr[AW +: AW]  = 21'h00123;
    push_cmd(1, 1'b0, 21'h00123);
    sample();
    check("lone_offer", {62'd0, m_ready}, 64'd2);
    check("lone_cmd_en", {63'd0, s_cmd_en}, 64'd1);
    check("lone_addr", {43'd0, s_addr}, 64'h123);
    tick();
    m_cmd_en = '0;
    sample();
    check("read_busy_ready", {62'd0, m_ready}, 64'd0);
    read_beats(1, 64'h100);

    // Contention: master 0 writes, master 1 reads, both strobing throughout.
    tick();
    s_rd_data_valid         = 1'b0;
    m_cmd                   = 2'b01;
    m_cmd_en                = 2'b11;
    m_addr[0 +: AW]         = 21'h00040;
    m_addr[AW +: AW]        = 21'h00080;
    m_wr_data[63:0]         = 64'hA;
    m_data_mask[7:0]        = 8'hFF;
    push_cmd(0, 1'b1, 21'h00040);
    sample();
    check("ptr_after_read", {62'd0, m_ready}, 64'd1);
    check("wr_cmd_en", {63'd0, s_cmd_en}, 64'd1);
    check("wr_beat0", s_wr_data, 64'hA);
    check("wr_mask", {56'd0, s_data_mask}, 64'hFF);
    write_beats(64'hA);

    tick();
    push_cmd(1, 1'b0, 21'h00080);
    sample();
    check("grant1_a", {62'd0, m_ready}, 64'd2);
    read_beats(1, 64'h300);

    tick();
    s_rd_data_valid = 1'b0;
    m_wr_data[63:0] = 64'hE;
    push_cmd(0, 1'b1, 21'h00040);
    sample();
    check("grant0_b", {62'd0, m_ready}, 64'd1);
    check("wr2_beat0", s_wr_data, 64'hE);
    write_beats(64'hE);

    tick();
    push_cmd(1, 1'b0, 21'h00080);
    sample();
    check("grant1_b", {62'd0, m_ready}, 64'd2);
    read_beats(1, 64'h400);

    // Backpressure: controller busy for 10 cycles while master 0 strobes.
    tick();
    s_rd_data_valid = 1'b0;
    s_ready         = 1'b0;
    m_cmd           = 2'b00;
    m_cmd_en        = 2'b01;
    m_addr[0 +: AW] = 21'h00007;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("bp_ready", {62'd0, m_ready}, 64'd0);
      check("bp_cmd_en", {63'd0, s_cmd_en}, 64'd0);
      tick();
    end
    s_ready = 1'b1;
    push_cmd(0, 1'b0, 21'h00007);
    sample();
    check("bp_grant0", {62'd0, m_ready}, 64'd1);
    check("bp_cmd_en_hi", {63'd0, s_cmd_en}, 64'd1);
    read_beats(0, 64'h500);
    tick();
    s_rd_data_valid = 1'b0;
    m_cmd_en        = '0;
    sample();
    check("bp_ptr_after", {62'd0, m_ready}, 64'd2);

    // Unsolicited beat in IDLE.
    tick();
    s_rd_data_valid = 1'b1;
    s_rd_data       = 64'hDEAD;
    sample();
    check("unsol_no_route", {62'd0, m_rd_data_valid}, 64'd0);
    tick();
    s_rd_data_valid = 1'b0;
    sample();
    check("unsol_err", {63'd0, err}, 64'd1);
    repeat (3) tick();
    sample();
    check("err_sticky", {63'd0, err}, 64'd1);

    // Reset mid-read: 2 beats, reset, then 2 late beats.
    tick();
    rst = 1'b1;
    tick();
    rst             = 1'b0;
    m_cmd           = 2'b00;
    m_cmd_en        = 2'b01;
    m_addr[0 +: AW] = 21'h00055;
    push_cmd(0, 1'b0, 21'h00055);
    sample();
    check("err_cleared_by_rst", {63'd0, err}, 64'd0);
    check("mr_offer0", {62'd0, m_ready}, 64'd1);
    check("mr_cmd_en", {63'd0, s_cmd_en}, 64'd1);
    for (int k = 0; k < 2; k++) begin
      rd_exp_t e;
      tick();
      m_cmd_en        = '0;
      s_rd_data_valid = 1'b1;
      s_rd_data       = 64'h600 + 64'(k);
      e.master        = 0;
      e.data          = s_rd_data;
      rd_q.push_back(e);
      sample();
      check("mr_beat", {62'd0, m_rd_data_valid}, 64'd1);
    end
    tick();
    s_rd_data_valid = 1'b0;
    rst             = 1'b1;
    sample();
    check("mr_rst_ready", {62'd0, m_ready}, 64'd0);
    check("mr_rst_cmd_en", {63'd0, s_cmd_en}, 64'd0);
    tick();
    rst             = 1'b0;
    s_rd_data_valid = 1'b1;
    s_rd_data       = 64'h602;
    sample();
    check("late_beat3_drop", {62'd0, m_rd_data_valid}, 64'd0);
    check("ptr0_after_rst", {62'd0, m_ready}, 64'd1);
    tick();
    s_rd_data       = 64'h603;
    sample();
    check("late_beat4_drop", {62'd0, m_rd_data_valid}, 64'd0);
    check("late_err", {63'd0, err}, 64'd1);
    tick();
    s_rd_data_valid = 1'b0;
    sample();
    check("late_err_hold", {63'd0, err}, 64'd1);

    check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
